// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns and issues data RAM accesses,
// extends load data, flags misaligned addresses and stalls upstream.
module mem_access_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     ram_data_i,
    input  logic                  ram_ready_i,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_sel_o,
    output logic [DATA_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic [DATA_W-1:0]     badvaddr_o
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_nxt;

    logic                  is_load, is_store, is_mem;
    logic                  sz_b, sz_h, sz_w;
    logic                  misaligned, accept, go_req, killed;
    logic [3:0]            sel_nxt;
    logic [DATA_W-1:0]     wdata_nxt, ld_data;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [3:0]            op_q;
    logic [1:0]            off_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q, ld_q, kill_q;

    // Decode op into direction and access size
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_b     = 1'b0;
        sz_h     = 1'b0;
        sz_w     = 1'b0;
        case (mem_op_i)
            4'd1, 4'd2: begin is_load = 1'b1;  sz_b = 1'b1; end
            4'd3, 4'd4: begin is_load = 1'b1;  sz_h = 1'b1; end
            4'd5:       begin is_load = 1'b1;  sz_w = 1'b1; end
            4'd6:       begin is_store = 1'b1; sz_b = 1'b1; end
            4'd7:       begin is_store = 1'b1; sz_h = 1'b1; end
            4'd8:       begin is_store = 1'b1; sz_w = 1'b1; end
            default:    ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (sz_h & addr_i[0]) | (sz_w & (|addr_i[1:0]));
    assign accept     = (state == IDLE) & valid_i & ~flush_i;
    assign go_req     = accept & is_mem & ~misaligned;
    assign stall_o    = go_req | ((state == REQ) & ~ram_ready_i);
    assign killed     = kill_q | flush_i;

    // Byte enables and lane-replicated store data for the request
    always_comb begin
        sel_nxt   = 4'b1111;
        wdata_nxt = store_data_i;
        if (sz_b) begin
            sel_nxt   = 4'b0001 << addr_i[1:0];
            wdata_nxt = {4{store_data_i[7:0]}};
        end else if (sz_h) begin
            sel_nxt   = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{store_data_i[15:0]}};
        end
    end

    // Select the addressed lane of RAM data and extend it
    always_comb begin
        case (off_q)
            2'd0:    lane_b = ram_data_i[7:0];
            2'd1:    lane_b = ram_data_i[15:8];
            2'd2:    lane_b = ram_data_i[23:16];
            default: lane_b = ram_data_i[31:24];
        endcase
        lane_h = off_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
        case (op_q)
            4'd1:    ld_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            4'd2:    ld_data = {{(DATA_W-8){1'b0}}, lane_b};
            4'd3:    ld_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            4'd4:    ld_data = {{(DATA_W-16){1'b0}}, lane_h};
            default: ld_data = ram_data_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: enter REQ on an aligned access, leave on ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_req) state_nxt = REQ;
            REQ:     if (ram_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered RAM request, writeback slot and latched op context
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ram_ce_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_sel_o   <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            valid_o     <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            adel_o      <= 1'b0;
            ades_o      <= 1'b0;
            badvaddr_o  <= '0;
            op_q        <= '0;
            off_q       <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            ld_q        <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            adel_o  <= 1'b0;
            ades_o  <= 1'b0;
            if (state == IDLE) begin
                if (accept && !is_mem) begin
                    valid_o <= 1'b1;
                    wd_o    <= wd_i;
                    wreg_o  <= wreg_i;
                    wdata_o <= wdata_i;
                end else if (accept && misaligned) begin
                    valid_o    <= 1'b1;
                    badvaddr_o <= addr_i;
                    adel_o     <= is_load;
                    ades_o     <= is_store;
                end else if (go_req) begin
                    ram_ce_o    <= 1'b1;
                    ram_we_o    <= is_store;
                    ram_sel_o   <= sel_nxt;
                    ram_addr_o  <= {addr_i[DATA_W-1:2], 2'b00};
                    ram_wdata_o <= wdata_nxt;
                    op_q        <= mem_op_i;
                    off_q       <= addr_i[1:0];
                    wd_q        <= wd_i;
                    wreg_q      <= wreg_i & is_load;
                    ld_q        <= is_load;
                    kill_q      <= 1'b0;
                end
            end else begin
                if (flush_i) kill_q <= 1'b1;
                if (ram_ready_i) begin
                    ram_ce_o <= 1'b0;
                    ram_we_o <= 1'b0;
                    if (!killed) begin
                        valid_o <= 1'b1;
                        wd_o    <= wd_q;
                        wreg_o  <= wreg_q;
                        if (ld_q) wdata_o <= ld_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus tasks queue expected
// writebacks, a negedge monitor pops and compares each valid_o.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic [31:0] ram_data_i;
    logic        ram_ready_i;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        stall_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
        bit          ck_wd;
        bit          ck_wdata;
        bit          ck_bad;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    mem_access_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .mem_op_i(mem_op_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .ram_data_i(ram_data_i),
        .ram_ready_i(ram_ready_i), .ram_ce_o(ram_ce_o),
        .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .adel_o(adel_o),
        .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expectation
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid_o=1 expected none at %0t",
                         $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_wreg", {31'd0, wreg_o}, {31'd0, e.wreg});
                chk("wb_adel", {31'd0, adel_o}, {31'd0, e.adel});
                chk("wb_ades", {31'd0, ades_o}, {31'd0, e.ades});
                if (e.ck_wd)    chk("wb_wd", {27'd0, wd_o}, {27'd0, e.wd});
                if (e.ck_wdata) chk("wb_wdata", wdata_o, e.wdata);
                if (e.ck_bad)   chk("wb_badvaddr", badvaddr_o, e.bad);
            end
        end
    end

    task automatic do_alu(input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata);
        exp_t e;
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = 4'd0; wd_i = wd;
        wreg_i = wreg; wdata_i = wdata; addr_i = 32'h0000_0001;
        @(negedge clk_i);
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        e = '{wd, wreg, wdata, 1'b0, 1'b0, 32'd0, 1, 1, 0};
        exp_q.push_back(e);
    endtask

    task automatic idle;
        @(posedge clk_i); #1;
        valid_i = 1'b0; mem_op_i = 4'd0; flush_i = 1'b0;
    endtask

    task automatic do_mem(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int delay, input logic [4:0] wd,
                          input logic [3:0] esel, input logic [31:0] eaddr,
                          input logic [31:0] ewdata, input logic [31:0] eres,
                          input bit st);
        exp_t e;
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = op; addr_i = addr;
        store_data_i = sdata; wd_i = wd; wreg_i = 1'b1;
        wdata_i = 32'h5555_5555; ram_data_i = rdata;
        @(negedge clk_i);
        chk("mem_stall_accept", {31'd0, stall_o}, 32'd1);
        e = '{wd, !st, eres, 1'b0, 1'b0, 32'd0, 1, !st, 0};
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        chk("ram_ce", {31'd0, ram_ce_o}, 32'd1);
        chk("ram_we", {31'd0, ram_we_o}, {31'd0, st});
        chk("ram_sel", {28'd0, ram_sel_o}, {28'd0, esel});
        chk("ram_addr", ram_addr_o, eaddr);
        if (st) chk("ram_wdata", ram_wdata_o, ewdata);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_i);
            chk("req_stall", {31'd0, stall_o}, 32'd1);
            @(posedge clk_i); #1;
            chk("req_ce_hold", {31'd0, ram_ce_o}, 32'd1);
            chk("req_sel_hold", {28'd0, ram_sel_o}, {28'd0, esel});
            if (st) chk("req_wdata_hold", ram_wdata_o, ewdata);
        end
        ram_ready_i = 1'b1;
        @(negedge clk_i);
        chk("ready_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        ram_ready_i = 1'b0; valid_i = 1'b0; mem_op_i = 4'd0;
        chk("done_ce", {31'd0, ram_ce_o}, 32'd0);
    endtask

    task automatic do_mis(input logic [3:0] op, input logic [31:0] addr,
                          input bit st);
        exp_t e;
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = op; addr_i = addr;
        wd_i = 5'd9; wreg_i = 1'b1; store_data_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        e = '{5'd0, 1'b0, 32'd0, !st, st, addr, 0, 0, 1};
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        valid_i = 1'b0; mem_op_i = 4'd0;
        chk("mis_no_ce", {31'd0, ram_ce_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0; addr_i = '0;
        store_data_i = '0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        flush_i = 1'b0; ram_data_i = '0; ram_ready_i = 1'b0;
        #12;
        chk("rst_ce", {31'd0, ram_ce_o}, 32'd0);
        chk("rst_we", {31'd0, ram_we_o}, 32'd0);
        chk("rst_sel", {28'd0, ram_sel_o}, 32'd0);
        chk("rst_addr", ram_addr_o, 32'd0);
        chk("rst_wdata_ram", ram_wdata_o, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_wd", {27'd0, wd_o}, 32'd0);
        chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_adel", {31'd0, adel_o}, 32'd0);
        chk("rst_ades", {31'd0, ades_o}, 32'd0);
        chk("rst_bad", badvaddr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_alu(5'd3, 1'b1, 32'h0000_1234);
        do_alu(5'd7, 1'b0, 32'h0BAD_F00D);
        idle();

        do_mem(4'd1, 32'h1003, 0, 32'h80FF_FFFF, 0, 5'd4,
               4'b1000, 32'h1000, 0, 32'hFFFF_FF80, 0);
        do_mem(4'd2, 32'h1003, 0, 32'h80FF_FFFF, 0, 5'd5,
               4'b1000, 32'h1000, 0, 32'h0000_0080, 0);
        do_mem(4'd1, 32'h1001, 0, 32'h0000_7F00, 0, 5'd6,
               4'b0010, 32'h1000, 0, 32'h0000_007F, 0);
        do_mem(4'd3, 32'h1002, 0, 32'h80FF_1234, 0, 5'd8,
               4'b1100, 32'h1000, 0, 32'hFFFF_80FF, 0);
        do_mem(4'd4, 32'h1000, 0, 32'h80FF_1234, 1, 5'd10,
               4'b0011, 32'h1000, 0, 32'h0000_1234, 0);
        do_mem(4'd5, 32'h3000, 0, 32'hDEAD_BEEF, 1, 5'd11,
               4'b1111, 32'h3000, 0, 32'hDEAD_BEEF, 0);
        do_mem(4'd7, 32'h2002, 32'hAAAA_BEEF, 0, 3, 5'd12,
               4'b1100, 32'h2000, 32'hBEEF_BEEF, 0, 1);
        do_mem(4'd6, 32'h2001, 32'h1234_56A5, 0, 0, 5'd13,
               4'b0010, 32'h2000, 32'hA5A5_A5A5, 0, 1);
        do_mem(4'd8, 32'h2004, 32'h1122_3344, 0, 2, 5'd14,
               4'b1111, 32'h2004, 32'h1122_3344, 0, 1);

        do_mis(4'd5, 32'h3001, 0);
        do_mis(4'd8, 32'h3002, 1);
        do_mis(4'd4, 32'h3003, 0);
        do_mis(4'd7, 32'h3005, 1);

        // flush in IDLE: nothing accepted, no stall
        @(posedge clk_i); #1;
        valid_i = 1'b1; flush_i = 1'b1; mem_op_i = 4'd5;
        addr_i = 32'h4000;
        @(negedge clk_i);
        chk("flush_idle_stall", {31'd0, stall_o}, 32'd0);
        idle();
        chk("flush_idle_ce", {31'd0, ram_ce_o}, 32'd0);

        // flush during REQ: handshake completes, result killed
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h4000;
        wd_i = 5'd15; wreg_i = 1'b1; ram_data_i = 32'h1357_9BDF;
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        chk("fl_ce", {31'd0, ram_ce_o}, 32'd1);
        @(negedge clk_i);
        chk("fl_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("fl_ce_hold", {31'd0, ram_ce_o}, 32'd1);
        @(posedge clk_i); #1;
        ram_ready_i = 1'b1;
        chk("fl_ce_hold2", {31'd0, ram_ce_o}, 32'd1);
        @(posedge clk_i); #1;
        ram_ready_i = 1'b0; valid_i = 1'b0; mem_op_i = 4'd0;
        chk("fl_ce_done", {31'd0, ram_ce_o}, 32'd0);
        @(negedge clk_i);
        chk("fl_valid", {31'd0, valid_o}, 32'd0);
        chk("fl_wreg", {31'd0, wreg_o}, 32'd0);

        // asynchronous reset in the middle of REQ
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h5000;
        wd_i = 5'd16; wreg_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rr_ce_before", {31'd0, ram_ce_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rr_ce", {31'd0, ram_ce_o}, 32'd0);
        chk("rr_valid", {31'd0, valid_o}, 32'd0);
        valid_i = 1'b0; mem_op_i = 4'd0;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        do_mem(4'd5, 32'h5000, 0, 32'h0F0F_A5A5, 1, 5'd17,
               4'b1111, 32'h5000, 0, 32'h0F0F_A5A5, 0);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes the EX result (target register, write enable, ALU data) plus a memory-op code, address and store data.
- Runs a ready-handshaked access on the data RAM port: byte-lane alignment, load extension, misalignment detection, pipeline stall.
- Presents registered writeback data to MEM/WB.

Parameters:
- DATA_W, 32, data/address width; only 32 supported.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- valid_i  in  1  EX/MEM slot holds a live instruction.
- mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
- addr_i  in  32  effective byte address.
- store_data_i  in  32  rt value for stores.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  destination write enable.
- wdata_i  in  32  ALU result, used when not a load.
- flush_i  in  1  kill the current and in-flight instruction.
- ram_data_i  in  32  RAM read data, valid with ram_ready_i.
- ram_ready_i  in  1  RAM completes the access this cycle.
- ram_ce_o  out  1  RAM request.
- ram_we_o  out  1  1 = write.
- ram_sel_o  out  4  byte enables; bit0 = byte at addr 4n.
- ram_addr_o  out  32  word address, {addr[31:2],2'b00}.
- ram_wdata_o  out  32  lane-replicated store data.
- stall_o  out  1  upstream must hold its inputs; combinational.
- valid_o  out  1  writeback slot valid.
- wd_o  out  REG_ADDR_W  destination register.
- wreg_o  out  1  write enable to MEM/WB.
- wdata_o  out  32  writeback data.
- adel_o  out  1  load address error.
- ades_o  out  1  store address error.
- badvaddr_o  out  32  faulting address.

Behaviour:
- Reset (async, any state): state=IDLE. All registered outputs are 0: ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o, valid_o, wd_o, wreg_o, wdata_o, adel_o, ades_o, badvaddr_o. An in-flight RAM access is abandoned.
- States: IDLE, REQ. All outputs except stall_o are registered.
- Inputs are sampled only in IDLE with valid_i=1 and flush_i=0. Otherwise, in IDLE, the next cycle has valid_o=0.
- Misalignment: LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0.
- Non-memory op (mem_op none): next cycle valid_o=1, wd_o/wreg_o/wdata_o copied from inputs, stay IDLE. Latency 1, throughput 1/cycle.
- Misaligned op: no RAM access. Next cycle valid_o=1, wreg_o=0, badvaddr_o=addr_i, adel_o=1 for a load or ades_o=1 for a store. Stay IDLE.
- Aligned memory op: go to REQ. Register ram_ce_o=1, ram_addr_o, ram_sel_o, ram_we_o (1 for stores). Latch wd_i, wreg_i and op into the unit.
- ram_sel_o:
  - byte ops: 1<<addr[1:0].
  - half ops: addr[1] ? 4'b1100 : 4'b0011.
  - word ops: 4'b1111.
- ram_wdata_o: SB = byte replicated x4; SH = halfword replicated x2; SW = as-is.
- REQ: hold all ram_* outputs stable until ram_ready_i=1. On that edge, ram_ce_o=0, ram_we_o=0, return to IDLE, and valid_o=1 next cycle.
  - Loads: wdata_o = selected lane; LB/LH sign-extend, LBU/LHU zero-extend. wreg_o = latched wreg.
  - Stores: wreg_o=0.
- stall_o = (IDLE & valid_i & !flush_i & aligned memory op) | (REQ & !ram_ready_i).
  - The accepted instruction stays presented during REQ and is ignored there.
  - Upstream advances on the ram_ready_i edge.
- Minimum memory-op occupancy: 2 cycles (accept, REQ+ready). Result appears 2 cycles after accept.
- flush_i in REQ: the handshake still completes (ram_* held until ready), but the result is killed (valid_o=0, wreg_o=0). flush_i in IDLE: input not accepted.
- valid_o, adel_o and ades_o are single-cycle pulses per instruction. wd_o, wdata_o and badvaddr_o hold their values when valid_o=0.
- ram_ready_i in IDLE is ignored.

Test Plan:
- Non-mem op: valid_i=1, op=0, wd=3, wreg=1, wdata=0x1234 -> next cycle valid_o=1, wd_o=3, wdata_o=0x1234, stall_o=0 throughout.
- LB at 0x1003, ram_ready_i in the first REQ cycle, ram_data_i=0x80FF_FFFF:
  - ram_addr_o=0x1000, ram_sel_o=4'b1000, ram_we_o=0.
  - wdata_o=0xFFFF_FF80 at accept+2; the LBU variant gives 0x0000_0080.
- SH at 0x2002, data 0xAAAA_BEEF, ram_ready_i delayed 3 cycles:
  - stall_o=1 for 1+3 cycles, ram_sel_o=4'b1100, ram_wdata_o=0xBEEF_BEEF held stable.
  - valid_o=1 with wreg_o=0 after ready.
- LW at 0x3001 -> no ram_ce_o, next cycle valid_o=1, adel_o=1, badvaddr_o=0x3001, wreg_o=0. The SW variant asserts ades_o instead.
- flush_i pulsed during REQ of an LW with ready 2 cycles later -> the RAM handshake completes, then valid_o=0 and wreg_o=0.
- rst_i asserted mid-REQ, not on a clock edge -> ram_ce_o=0 and valid_o=0 immediately. After release, a new LW completes normally.
